// File: rtl/div_ctrl.sv
// div_ctrl: runtime-programmable clock divider with run/stop/single-step
// sequencing and a valid/ready divisor configuration port.
//
// The divided clock o_clk toggles every div_act cycles while the block is
// RUN or STEP. A divisor change and a stop only take effect at a
// half-period boundary (wrap), so o_clk never has a truncated phase.
//
// State table:
//   STOP | counter held at 0, o_clk held, divisor writes land immediately
//   RUN  | counting continuously; leaves to STOP at a wrap with i_run=0
//   STEP | counting for exactly one half-period, then RUN or STOP
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_run        level, request continuous running
//   i_step       pulse, request one half-period while stopped
//   i_cfg_valid  new divisor offered
//   i_cfg_div    offered divisor (0 is treated as 1)
//   o_cfg_ready  config port can accept (no pending divisor)
//   o_clk        divided clock
//   o_tick       one-cycle strobe, high in the cycle after each o_clk toggle
//   o_busy       state is RUN or STEP
//   o_div        currently active divisor
module div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  input  logic         i_step,
  input  logic         i_cfg_valid,
  input  logic [W-1:0] i_cfg_div,
  output logic         o_cfg_ready,
  output logic         o_clk,
  output logic         o_tick,
  output logic         o_busy,
  output logic [W-1:0] o_div
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] DIV_INIT = W'(DEFAULT_DIV);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] div_pend_q, div_pend_d;
  logic         pend_q, pend_d;

  logic         busy;
  logic         wrap;
  logic         xfer;
  logic [W-1:0] cfg_val;

  assign busy    = (state_q != ST_STOP);
  // div_act_q is never 0 (reset value and clamped writes), so -1 cannot underflow.
  assign wrap    = busy && (cnt_q == (div_act_q - ONE));
  assign xfer    = i_cfg_valid && !pend_q;
  assign cfg_val = (i_cfg_div == '0) ? ONE : i_cfg_div;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;

    if (!busy) begin
      cnt_d = '0;
      if (xfer) begin
        div_act_d = cfg_val;
      end
      if (i_run) begin
        state_d = ST_RUN;
      end else if (i_step) begin
        state_d = ST_STEP;
      end
    end else begin
      if (wrap) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        // The pending divisor (if any) is applied here, including when
        // this wrap ends in STOP.
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
        // RUN and STEP leave the same way: keep running only if asked to.
        state_d = i_run ? ST_RUN : ST_STOP;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // xfer implies pend_q=0, so this never collides with the clear above;
      // a value accepted on a wrap waits for the following wrap.
      if (xfer) begin
        div_pend_d = cfg_val;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      div_act_q  <= DIV_INIT;
      div_pend_q <= DIV_INIT;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
    end
  end

  assign o_cfg_ready = !pend_q;
  assign o_clk       = clk_q;
  assign o_tick      = tick_q;
  assign o_busy      = busy;
  assign o_div       = div_act_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_run = 1'b0;
  logic         i_step = 1'b0;
  logic         i_cfg_valid = 1'b0;
  logic [W-1:0] i_cfg_div = '0;
  logic         o_cfg_ready;
  logic         o_clk;
  logic         o_tick;
  logic         o_busy;
  logic [W-1:0] o_div;

  div_ctrl #(.W(W), .DEFAULT_DIV(10)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (i_run),
    .i_step      (i_step),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_ready (o_cfg_ready),
    .o_clk       (o_clk),
    .o_tick      (o_tick),
    .o_busy      (o_busy),
    .o_div       (o_div)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected toggles: edge number of the toggle and new o_clk.
  typedef struct {
    int   cyc;
    logic clk;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  always @(negedge i_clk) begin
    if (mon_en && o_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick after edge %0d o_clk=%0b, required no toggle", cyc, o_clk);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || o_clk !== mon_e.clk) begin
          errors++;
          $display("FAIL tick_sb: toggle edge %0d o_clk=%0b, required edge %0d o_clk=%0b",
                   cyc, o_clk, mon_e.cyc, mon_e.clk);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input int c, input logic v);
    exp_t t;
    t.cyc = c;
    t.clk = v;
    exp_q.push_back(t);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge i_clk);
  endtask

  // Reset released on a negedge; the next posedge is edge base+1.
  task automatic apply_reset(input logic run, output int base);
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_run = 1'b0;
    i_step = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_div = '0;
    repeat (2) @(negedge i_clk);
    i_run = run;
    @(negedge i_clk);
    i_rst = 1'b0;
    base = cyc;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: o_clk=%0b required 0", o_clk); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: o_tick=%0b required 0", o_tick); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: o_busy=%0b required 0", o_busy); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: o_cfg_ready=%0b required 1", o_cfg_ready); end
    checks++; if (o_div !== 8'd10) begin errors++; $display("FAIL rst_div: o_div=%0d required 10", o_div); end
  endtask

  task automatic test_run_from_reset();
    int b;
    apply_reset(1'b1, b);
    for (int k = 0; k < 4; k++) push_exp(b + 11 + 10 * k, (k % 2 == 0));
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL run_busy0: o_busy=%0b required 0", o_busy); end
    wait_cyc(b + 1);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL run_busy1: o_busy=%0b required 1", o_busy); end
    wait_cyc(b + 10);
    checks++; if (o_clk !== 1'b0) begin errors++; $display("FAIL run_preclk: o_clk=%0b required 0", o_clk); end
    wait_cyc(b + 45);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_cfg_midrun();
    int b;
    apply_reset(1'b1, b);
    push_exp(b + 11, 1'b1);
    push_exp(b + 21, 1'b0);
    push_exp(b + 25, 1'b1);
    push_exp(b + 29, 1'b0);
    push_exp(b + 33, 1'b1);
    wait_cyc(b + 14);  // cnt=3
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_pre: o_cfg_ready=%0b required 1", o_cfg_ready); end
    i_cfg_valid = 1'b1;
    i_cfg_div = 8'd4;
    wait_cyc(b + 15);
    i_cfg_valid = 1'b0;
    checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pend: o_cfg_ready=%0b required 0", o_cfg_ready); end
    checks++; if (o_div !== 8'd10) begin errors++; $display("FAIL cfg_div_pend: o_div=%0d required 10", o_div); end
    wait_cyc(b + 20);
    checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_prewrap: o_cfg_ready=%0b required 0", o_cfg_ready); end
    wait_cyc(b + 21);
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_post: o_cfg_ready=%0b required 1", o_cfg_ready); end
    checks++; if (o_div !== 8'd4) begin errors++; $display("FAIL cfg_div_post: o_div=%0d required 4", o_div); end
    wait_cyc(b + 35);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cfg_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_stop_midrun();
    int b;
    int changed;
    apply_reset(1'b1, b);
    push_exp(b + 11, 1'b1);
    push_exp(b + 21, 1'b0);
    wait_cyc(b + 13);  // cnt=2
    i_run = 1'b0;
    wait_cyc(b + 20);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stop_busy_pre: o_busy=%0b required 1", o_busy); end
    wait_cyc(b + 21);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_busy_post: o_busy=%0b required 0", o_busy); end
    checks++; if (o_clk !== 1'b0) begin errors++; $display("FAIL stop_clk: o_clk=%0b required 0", o_clk); end
    changed = 0;
    for (int k = 22; k < 57; k++) begin
      wait_cyc(b + k);
      if (o_clk !== 1'b0) changed++;
    end
    checks++; if (changed != 0) begin errors++; $display("FAIL stop_hold: o_clk off-level %0d cycles, required 0", changed); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_step();
    int b;
    int s;
    apply_reset(1'b0, b);
    wait_cyc(b + 2);
    i_cfg_valid = 1'b1;
    i_cfg_div = 8'd3;
    wait_cyc(b + 3);
    i_cfg_valid = 1'b0;
    checks++; if (o_div !== 8'd3) begin errors++; $display("FAIL step_div: o_div=%0d required 3", o_div); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL step_ready: o_cfg_ready=%0b required 1", o_cfg_ready); end
    s = cyc;
    push_exp(s + 4, 1'b1);
    i_step = 1'b1;
    wait_cyc(s + 1);
    i_step = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL step_busy: o_busy=%0b required 1", o_busy); end
    wait_cyc(s + 2);
    i_step = 1'b1;
    wait_cyc(s + 3);
    i_step = 1'b0;
    wait_cyc(s + 4);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL step_stop: o_busy=%0b required 0", o_busy); end
    wait_cyc(s + 20);
    checks++; if (o_clk !== 1'b1) begin errors++; $display("FAIL step_clk: o_clk=%0b required 1", o_clk); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL step_idle: o_busy=%0b required 0", o_busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL step_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_div1();
    int b;
    int r;
    int low;
    apply_reset(1'b0, b);
    wait_cyc(b + 1);
    i_cfg_valid = 1'b1;
    i_cfg_div = 8'd0;
    wait_cyc(b + 2);
    i_cfg_valid = 1'b0;
    checks++; if (o_div !== 8'd1) begin errors++; $display("FAIL div1_clamp: o_div=%0d required 1", o_div); end
    r = cyc;
    for (int k = 0; k < 10; k++) push_exp(r + 2 + k, (k % 2 == 0));
    i_run = 1'b1;
    low = 0;
    for (int k = 2; k <= 11; k++) begin
      wait_cyc(r + k);
      if (o_tick !== 1'b1) low++;
      if (k == 10) i_run = 1'b0;
    end
    checks++; if (low != 0) begin errors++; $display("FAIL div1_tick: o_tick low %0d cycles, required 0", low); end
    wait_cyc(r + 15);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL div1_stop: o_busy=%0b required 0", o_busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL div1_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int b;
    apply_reset(1'b1, b);
    push_exp(b + 11, 1'b1);
    wait_cyc(b + 13);
    i_cfg_valid = 1'b1;
    i_cfg_div = 8'd5;
    wait_cyc(b + 14);
    i_cfg_valid = 1'b0;
    checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL ar_pend: o_cfg_ready=%0b required 0", o_cfg_ready); end
    checks++; if (o_clk !== 1'b1) begin errors++; $display("FAIL ar_preclk: o_clk=%0b required 1", o_clk); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ar_missing: %0d toggles outstanding, required 0", exp_q.size()); end
    mon_en = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++; if (o_clk !== 1'b0) begin errors++; $display("FAIL ar_clk: o_clk=%0b required 0", o_clk); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ar_busy: o_busy=%0b required 0", o_busy); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: o_cfg_ready=%0b required 1", o_cfg_ready); end
    checks++; if (o_div !== 8'd10) begin errors++; $display("FAIL ar_div: o_div=%0d required 10", o_div); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL ar_tick: o_tick=%0b required 0", o_tick); end
    @(negedge i_clk);
    i_run = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_div !== 8'd10) begin errors++; $display("FAIL ar_div_rel: o_div=%0d required 10", o_div); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL ar_ready_rel: o_cfg_ready=%0b required 1", o_cfg_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ar_busy_rel: o_busy=%0b required 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_run_from_reset();
    test_cfg_midrun();
    test_stop_midrun();
    test_step();
    test_div1();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Runtime-programmable clock-divider controller for the Lenia pipeline. It owns the divide counter and generates the divided clock `o_clk` plus a one-cycle strobe `o_tick`, using the same half-period semantics as the existing divider. It adds run/stop/single-step sequencing and a valid/ready configuration port. Divisor changes and stops take effect only at half-period boundaries, so no truncated `o_clk` phase is ever produced.

## Interface
- `W`, 8: width of the divisor and counter.
- `DEFAULT_DIV`, 10: active divisor after reset, in the range 1..2^W-1.

- `i_clk` input 1: system clock.
- `i_rst` input 1: reset. Asynchronous, active-high.
- `i_run` input 1: level. 1 requests continuous running.
- `i_step` input 1: pulse. Requests exactly one half-period while stopped.
- `i_cfg_valid` input 1: new divisor offered.
- `i_cfg_div` input W: offered divisor.
- `o_cfg_ready` output 1: config port can accept.
- `o_clk` output 1: divided clock.
- `o_tick` output 1: one-cycle strobe on each `o_clk` toggle.
- `o_busy` output 1: 1 when the state is RUN or STEP.
- `o_div` output W: currently active divisor.

## Operation
- Registers:
  - `state` ∈ {STOP, RUN, STEP}
  - `cnt[W-1:0]`
  - `div_act`
  - `div_pend`
  - `pend`
- Reset values:
  - `state`=STOP, `cnt`=0, `o_clk`=0, `o_tick`=0.
  - `div_act`=DEFAULT_DIV, `pend`=0.
  - `o_cfg_ready`=1, `o_busy`=0, `o_div`=DEFAULT_DIV.
- `wrap` = (state ≠ STOP) && (`cnt` == `div_act`-1).
- RUN and STEP counting:
  - When not wrap: `cnt`++.
  - On wrap: `cnt`←0, `o_clk` toggles, `o_tick`←1. Otherwise `o_tick`←0.
- STOP:
  - `cnt` is held at 0 and `o_clk` is held.
  - If `i_run`=1, go to RUN.
  - Else if `i_step`=1, go to STEP.
  - `i_run` has priority over `i_step`.
- RUN: on wrap with `i_run`=0, go to STOP. Dropping `i_run` mid-half-period never shortens that half-period.
- STEP: on wrap, go to RUN if `i_run`=1, else go to STOP. `i_step` is ignored outside STOP.
- Config handshake:
  - `o_cfg_ready` = !`pend`.
  - A transfer occurs when `i_cfg_valid` && `o_cfg_ready`.
  - An accepted value of 0 is clamped to 1.
  - In STOP, the accepted value is written directly to `div_act` and `pend` stays 0.
  - In RUN or STEP, the value goes to `div_pend` and `pend`←1. At the next wrap, `div_act`←`div_pend` and `pend`←0.
  - A transfer in the same cycle as a wrap is not applied at that wrap. It is applied at the following wrap.
  - On a transition from RUN or STEP to STOP with `pend`=1, the pending value is applied at that same wrap.
- `o_busy` = (state ≠ STOP). `o_div` = `div_act`.
- Async reset at any time forces all reset values immediately. A pending config is discarded.

## Timing
- Half-period is `div_act` cycles, so the `o_clk` period is 2·`div_act` cycles.
  - `div_act`=1 toggles `o_clk` every cycle.
- Latency from `i_run` sampled 1 in STOP to the first toggle is 1+`div_act` edges: one edge to enter RUN, then `div_act` counting edges.
- `o_tick` is registered and is high exactly in the cycle following the edge on which `o_clk` toggled.
- A new divisor affects the half-period that starts after the wrap that applies it. `o_cfg_ready` returns to 1 on that same edge.
- All outputs are registered except `o_cfg_ready`, `o_busy` and `o_div`, which are direct decodes of registers.

## Test plan
- Reset release with `i_run`=1 held and div 10:
  - First `o_clk` rise occurs 11 edges after reset release.
  - Subsequent toggles occur every 10 edges.
  - `o_tick` is a single-cycle pulse at each toggle.
  - `o_busy`=1 from edge 1 onward.
- In RUN at div 10, present cfg 4 when `cnt`=3:
  - Accepted that cycle; `o_cfg_ready`=0 until the wrap.
  - The current half-period remains 10 cycles; all later half-periods are 4.
  - `o_div` reads 4 and `o_cfg_ready`=1 after the wrap.
- In RUN at div 10, drop `i_run` at `cnt`=2:
  - The half-period completes at 10 cycles, `o_clk` toggles once, the block enters STOP and `o_busy`=0.
  - `o_clk` then holds its value for 30+ cycles.
- In STOP, cfg 3 is applied immediately (`o_div`=3). Then pulse `i_step` for 1 cycle, and pulse it again 1 cycle later:
  - Exactly one toggle occurs, 4 edges after the first pulse.
  - The block returns to STOP.
  - The second pulse is ignored.
- In STOP, cfg 0 gives `o_div`=1. Then set `i_run`=1:
  - `o_clk` toggles every edge, giving a period of 2.
  - `o_tick` is held high continuously.
- In RUN with `pend`=1, assert `i_rst` between clock edges:
  - All outputs take reset values immediately, without a clock edge.
  - After release, `o_div`=10 and `o_cfg_ready`=1; the pending value is lost.
